send_number: RTL and testbench
==============================

# send_number

Transmit-side counterpart of the board's 32-bit UART number link. It accepts a 32-bit word on a single-cycle start strobe and serialises it as four 8N1 UART frames, least-significant byte first. The UART bit-level transmitter is built in. It sits between on-chip logic producing a value and the board's tx pin, and is the byte-order and framing match for the receive path.

## Interface
- CLKS_PER_BIT, 1250: clock cycles per UART bit; legal range ≥ 2; internal counter width = $clog2(CLKS_PER_BIT).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset; **synchronous, active-high**.
- start  in  1  request to send `data`; sampled only while busy=0.
- data  in  32  word to send; latched on the accepting edge.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high from the accepting edge until the transfer completes.
- done  out  1  single-cycle pulse at transfer completion.

## Operation
- All outputs are registered. Reset values: tx=1, busy=0, done=0. Byte index, bit index and counters reset to 0.
- States:
  - IDLE
  - START_BIT
  - DATA_BITS
  - STOP_BIT
- Acceptance (IDLE, start=1 at an edge):
  - Latch data into a shift register.
  - busy←1, tx←0, byte index←0, enter START_BIT.
  - In IDLE with start=0, tx stays 1.
- Every bit state holds tx constant for exactly CLKS_PER_BIT cycles.
- START_BIT: tx=0, then go to DATA_BITS.
- DATA_BITS: sends bits 0..7 of the current byte, LSB first, then goes to STOP_BIT.
- STOP_BIT: tx=1.
  - If byte index < 3: increment byte index and go to START_BIT. There is no idle gap between frames.
  - If byte index = 3: busy←0, done←1 for one cycle, go to IDLE.
- Byte order on the line: data[7:0], data[15:8], data[23:16], data[31:24].
- start while busy=1 is ignored. No queuing, no error flag.
- Changes to data while busy=1 have no effect on the word being sent.
- rst at any point, including mid-bit, forces reset values at the next edge. A partial frame is truncated and done does not pulse for the aborted word.
- rst has priority over start in the same cycle.

## Timing
- Edge k accepts start. After edge k: tx=0, busy=1.
- Bit n of the whole transfer (n = 0..39, 10 bits per frame) occupies the cycles after edges k+n·C through k+(n+1)·C−1, where C = CLKS_PER_BIT.
- At edge k+40·C:
  - busy←0, done←1, tx remains 1.
  - done falls at edge k+40·C+1.
- A start present at edge k+40·C is ignored, because busy was still 1.
- The earliest next accept is edge k+40·C+1. The minimum start-to-start spacing is therefore 40·C+1 cycles.
- Latency from accepting edge to first tx falling edge: 0 cycles (tx low immediately after the accepting edge).
- Total transfer time: 40·C cycles.

## Test plan
- **Reset:** hold rst=1 for 3 cycles with start=1 → tx=1, busy=0, done=0 throughout. No frame starts while rst=1.
- **Single word:** C=4, data=0x12345678, start for 1 cycle →
  - tx shows frames carrying 0x78, 0x56, 0x34, 0x12, each as start 0, 8 bits LSB-first, stop 1, each bit 4 cycles wide.
  - busy is high for exactly 160 cycles.
  - done pulses once, on the cycle busy falls.
- **Ignore while busy:** C=4, send 0x000000FF. Mid-transfer, assert start with data=0xDEADBEEF for 10 cycles → line still carries FF,00,00,00. Exactly one done pulse.
- **Back-to-back:** C=4, send 0xA5A50F0F, then assert start continuously with data=0x5A5AF0F0 →
  - The second word is accepted at the edge after done, giving 161-cycle start-to-start spacing.
  - Frames carry 0F,0F,A5,A5 then F0,F0,5A,5A.
- **Reset mid-transfer:** C=4, send 0xCAFEBABE and assert rst during byte 2's data bits →
  - tx=1 and busy=0 after the next edge. No done pulse.
  - A following start with 0x01020304 transmits correctly.
- **Loopback:** C=16, tx wired to the team's uart_rx (CLKS_PER_BIT=16), send 0x89ABCDEF → four o_Rx_DV pulses with bytes EF, CD, AB, 89 in order.

Source files
------------

// File: rtl/send_number.sv
// 32-bit word serialiser: four back-to-back 8N1 UART frames, least-significant byte first.
// All outputs are registered; the FSM computes next values combinationally.
module send_number #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [2:0]        bit_idx, bit_idx_nx;
  logic [1:0]        byte_idx, byte_idx_nx;
  logic [31:0]       shift, shift_nx;
  logic              tx_nx, busy_nx, done_nx;
  logic              bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    shift_nx    = shift;
    tx_nx       = tx;
    busy_nx     = busy;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (start) begin
          shift_nx    = data;
          busy_nx     = 1'b1;
          tx_nx       = 1'b0;
          byte_idx_nx = '0;
          bit_idx_nx  = '0;
          cnt_nx      = '0;
          state_nx    = START_BIT;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          cnt_nx   = '0;
          tx_nx    = shift[0];
          state_nx = DATA_BITS;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      // tx is loaded one bit ahead of the shift, so shift[1] is the next bit to drive;
      // the eighth shift leaves the next byte's LSB in shift[0] for the following frame.
      DATA_BITS: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[31:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_nx = '0;
            tx_nx      = 1'b1;
            state_nx   = STOP_BIT;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = shift[1];
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (byte_idx == 2'd3) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            tx_nx    = 1'b1;
            state_nx = IDLE;
          end else begin
            byte_idx_nx = byte_idx + 2'd1;
            tx_nx       = 1'b0;
            state_nx    = START_BIT;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_send_number.sv
// Directed and randomized bench for send_number; the line is predicted from the
// time elapsed since acceptance using the 10-bits-per-frame, C-cycles-per-bit rule.
module tb_send_number;

  localparam int unsigned C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic        tx, busy, done;

  send_number #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: transfer active flag, latched word, cycles since accepting edge
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_word = '0;
  int          m_t    = 0;

  int cycle      = 0;
  int done_seen  = 0;
  int busy_count = 0;
  int rise_cycle = -1;
  int prev_rise  = -1;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic exp_tx();
    int n, frame, pos;
    if (!m_busy) return 1'b1;
    n     = m_t / int'(C);
    frame = n / 10;
    pos   = n % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_word[8*frame + pos - 1];
  endfunction

  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 40 * int'(C)) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_word = data;
    end
    #1;
    cycle++;
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("done", {31'b0, done}, {31'b0, m_done});
    if (done === 1'b1) done_seen++;
    if (busy === 1'b1) busy_count++;
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      prev_rise  = rise_cycle;
      rise_cycle = cycle;
    end
    prev_busy = busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    done_seen  = 0;
    busy_count = 0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    data  = $urandom;

    // reset held with start asserted: nothing may start
    run(3);
    rst   = 1'b0;
    start = 1'b0;
    run(4);

    // single word
    clear_counts();
    data  = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = $urandom;
    run(40 * C + 5);
    check("single_busy_cycles", busy_count, 160);
    check("single_done_pulses", done_seen, 1);

    // start while busy is ignored
    clear_counts();
    data  = 32'h0000_00FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(40);
    data  = 32'hDEAD_BEEF;
    start = 1'b1;
    run(10);
    start = 1'b0;
    run(40 * C - 50 + 5);
    check("ignore_done_pulses", done_seen, 1);

    // back-to-back with start held
    clear_counts();
    data  = 32'hA5A5_0F0F;
    start = 1'b1;
    tick();
    data  = 32'h5A5A_F0F0;
    run(40 * C + 1);
    start = 1'b0;
    data  = $urandom;
    run(40 * C + 5);
    check("b2b_done_pulses", done_seen, 2);
    check("b2b_spacing", rise_cycle - prev_rise, 40 * C + 1);

    // reset during byte 2 data bits
    clear_counts();
    data  = 32'hCAFE_BABE;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(22 * C + 1);
    rst = 1'b1;
    tick();
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    run(40 * C);
    check("abort_done_pulses", done_seen, 0);

    clear_counts();
    data  = 32'h0102_0304;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(40 * C + 5);
    check("after_abort_done_pulses", done_seen, 1);

    // randomized: sporadic starts with random words, occasional reset
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 9) == 0);
      data  = $urandom;
      rst   = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    run(40 * C + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
